foo_intf_array_reader: RTL and testbench

Consumer end of an unpacked array of `foo_intf`-style slots: N writer-side slots each present a valid/data word, and this block drains them in round-robin order into a single registered output stream. All per-slot access uses elaboration-time constant indices; a variable slot index is applied only to flattened packed vectors, never as a dotted select into the interface array. It serves as the regression-suite counterpart to the writer-side interface-array tests and as a reusable array-drain primitive.

---
 rtl/foo_intf_pkg.sv | 14 +
 rtl/foo_intf.sv | 11 +
 rtl/foo_intf_array_reader_rr_pick.sv | 28 ++
 rtl/foo_intf_array_reader.sv | 105 ++++++++++
 tb/tb_foo_intf_array_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/foo_intf_pkg.sv
// Shared types and helpers for the foo_intf slot array and its reader.
package foo_intf_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Index width for an N-entry slot array; never narrower than one bit.
  function automatic int IDX_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/foo_intf.sv
// One valid/data/ready slot; writers drive valid/data, the reader returns ready.
interface foo_intf #(
  parameter int W = 8
);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport rd (input valid, input data, output ready);
  modport wr (output valid, output data, input ready);
endinterface

// File: rtl/foo_intf_array_reader_rr_pick.sv
// Combinational round-robin picker: first set bit of vld at or above ptr, wrapping.
module rr_pick
  import foo_intf_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = IDX_W(N)
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] g,
  output logic          any
);

  int j;

  // Walk from farthest to nearest so the slot closest to ptr wins.
  always_comb begin
    g = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (vld[IW'(j)]) g = IW'(j);
    end
    any = |vld;
  end

endmodule

// File: rtl/foo_intf_array_reader.sv
// Drains an array of foo_intf slots round-robin into one registered output stream.
module foo_intf_array_reader
  import foo_intf_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = IDX_W(N)
) (
  input  logic          clk,
  input  logic          rst,
  foo_intf.rd           foos [N-1:0],
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  input  logic          out_ready,
  output logic [15:0]   xfer_count,
  output logic          proto_err
);

  logic [N-1:0]   vld;
  logic [N-1:0]   rdy;
  logic [N*W-1:0] dat;
  logic [N-1:0]   viol;

  logic [N-1:0]   prev_vld;
  logic [N-1:0]   prev_rdy;
  logic [N*W-1:0] prev_dat;

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  g;
  logic           any;
  logic           take;
  logic [W-1:0]   sel_data;
  logic [IW:0]    ptr_inc;
  logic [IW-1:0]  ptr_next;

  out_state_e state, state_next;

  // A slot violates the protocol if it was stalled last cycle and did not hold.
  for (genvar i = 0; i < N; i++) begin : g_flat
    assign vld[i]             = foos[i].valid;
    assign dat[i*W +: W]      = foos[i].data;
    assign foos[i].ready      = rdy[i];
    assign viol[i] = prev_vld[i] & ~prev_rdy[i] &
                     (~vld[i] | (dat[i*W +: W] != prev_dat[i*W +: W]));
  end

  rr_pick #(.N(N)) u_pick (
    .vld (vld),
    .ptr (ptr),
    .g   (g),
    .any (any)
  );

  assign out_valid = (state == FULL);
  assign take      = any && (state == EMPTY || out_ready) && !rst;

  always_comb begin
    rdy      = '0;
    sel_data = '0;
    if (take) rdy[g] = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (int'(g) == k) sel_data = dat[k*W +: W];
    end
    // g never exceeds N-1, so the increment reaches at most N.
    ptr_inc  = {1'b0, g} + (IW+1)'(1);
    ptr_next = (ptr_inc >= (IW+1)'(N)) ? '0 : ptr_inc[IW-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (take) state_next = FULL;
      FULL:    if (out_ready && !take) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_idx    <= '0;
      ptr        <= '0;
      xfer_count <= '0;
      proto_err  <= 1'b0;
      prev_vld   <= '0;
      prev_rdy   <= '0;
      prev_dat   <= '0;
    end else begin
      state    <= state_next;
      prev_vld <= vld;
      prev_rdy <= rdy;
      prev_dat <= dat;
      if (|viol) proto_err <= 1'b1;
      if (take) begin
        out_data <= sel_data;
        out_idx  <= g;
        ptr      <= ptr_next;
        if (xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_foo_intf_array_reader.sv
// Randomized directed bench for foo_intf_array_reader with a behavioural model (N=4) and a saturation run (N=3).
module tb_foo_intf_array_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // N=4 device
  logic        rst4;
  logic [3:0]  v4;
  logic [7:0]  d4 [4];
  wire  [3:0]  r4;
  logic        ordy4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  oi4;
  logic [15:0] cnt4;
  logic        err4;

  foo_intf #(.W(8)) foos4 [3:0] ();

  for (genvar i = 0; i < 4; i++) begin : g_drv4
    assign foos4[i].valid = v4[i];
    assign foos4[i].data  = d4[i];
    assign r4[i]          = foos4[i].ready;
  end

  foo_intf_array_reader #(.N(4), .W(8)) dut4 (
    .clk        (clk),
    .rst        (rst4),
    .foos       (foos4),
    .out_valid  (ov4),
    .out_data   (od4),
    .out_idx    (oi4),
    .out_ready  (ordy4),
    .xfer_count (cnt4),
    .proto_err  (err4)
  );

  // N=3 device for non-power-of-two wrap and counter saturation
  logic        rst3;
  logic [2:0]  v3;
  logic [7:0]  d3 [3];
  wire  [2:0]  r3;
  logic        ordy3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  oi3;
  logic [15:0] cnt3;
  logic        err3;

  foo_intf #(.W(8)) foos3 [2:0] ();

  for (genvar i = 0; i < 3; i++) begin : g_drv3
    assign foos3[i].valid = v3[i];
    assign foos3[i].data  = d3[i];
    assign r3[i]          = foos3[i].ready;
  end

  foo_intf_array_reader #(.N(3), .W(8)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .foos       (foos3),
    .out_valid  (ov3),
    .out_data   (od3),
    .out_idx    (oi3),
    .out_ready  (ordy3),
    .xfer_count (cnt3),
    .proto_err  (err3)
  );

  // Reference model of the N=4 device
  int         m_ptr;
  bit         m_ov;
  logic [7:0] m_od;
  int         m_oi;
  int         m_cnt;
  bit         m_err;
  bit   [3:0] p_v;
  bit   [3:0] p_r;
  logic [7:0] p_d [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
  endtask

  function automatic int grant4();
    for (int k = 0; k < 4; k++) begin
      if (v4[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic tick4();
    int         g;
    bit         take;
    logic [3:0] er;
    g    = grant4();
    take = (g >= 0) && (!m_ov || ordy4) && !rst4;
    er   = take ? 4'(1 << g) : 4'b0000;
    #1;
    check("ready", {28'b0, r4}, {28'b0, er});
    if (rst4) begin
      m_ptr = 0; m_ov = 0; m_od = 8'h00; m_oi = 0; m_cnt = 0; m_err = 0;
      p_v = '0; p_r = '0;
      for (int i = 0; i < 4; i++) p_d[i] = 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (p_v[i] && !p_r[i] && (!v4[i] || d4[i] !== p_d[i])) m_err = 1;
      end
      p_v = v4;
      p_r = er;
      for (int i = 0; i < 4; i++) p_d[i] = d4[i];
      if (take) begin
        m_od  = d4[g];
        m_oi  = g;
        m_ov  = 1;
        m_ptr = (g + 1) % 4;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (m_ov && ordy4) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid",  {31'b0, ov4},  {31'b0, m_ov});
    check("out_data",   {24'b0, od4},  {24'b0, m_od});
    check("out_idx",    {30'b0, oi4},  32'(m_oi));
    check("xfer_count", {16'b0, cnt4}, 32'(m_cnt));
    check("proto_err",  {31'b0, err4}, {31'b0, m_err});
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic rdy);
    v4    = v;
    ordy4 = rdy;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    v4   = 4'b0000;
    tick4();
    rst4 = 1'b0;
  endtask

  initial begin
    logic [7:0] w0;
    logic [7:0] w1;
    rst4 = 1'b1; v4 = 4'b0000; ordy4 = 1'b1;
    rst3 = 1'b1; v3 = 3'b000;  ordy3 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 8'h00;
    for (int i = 0; i < 3; i++) d3[i] = 8'h20 + 8'(i);
    m_ptr = 0; m_ov = 0; m_od = 8'h00; m_oi = 0; m_cnt = 0; m_err = 0;
    p_v = '0; p_r = '0;
    for (int i = 0; i < 4; i++) p_d[i] = 8'h00;
    @(negedge clk);

    $display("[TB] reset with all slots valid");
    apply_stimulus(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) d4[i] = 8'($urandom);
    tick4();
    tick4();
    check("reset_valid", {31'b0, ov4}, 32'd0);
    check("reset_count", {16'b0, cnt4}, 32'd0);
    rst4 = 1'b0;

    $display("[TB] single slot");
    apply_stimulus(4'b0100, 1'b1);
    d4[2] = 8'hA5;
    tick4();
    check("single_data", {24'b0, od4}, 32'h0000_00A5);
    check("single_idx",  {30'b0, oi4}, 32'd2);
    check("single_cnt",  {16'b0, cnt4}, 32'd1);
    apply_stimulus(4'b0000, 1'b1);
    tick4();

    $display("[TB] round robin");
    reset4();
    for (int i = 0; i < 4; i++) d4[i] = 8'h10 + 8'(i);
    apply_stimulus(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick4();
      check("rr_idx",  {30'b0, oi4}, 32'(k % 4));
      check("rr_data", {24'b0, od4}, 32'h10 + 32'(k % 4));
    end

    $display("[TB] backpressure");
    reset4();
    w0 = 8'($urandom);
    w1 = w0 ^ 8'h5A;
    d4[1] = w0;
    apply_stimulus(4'b0010, 1'b1);
    tick4();
    d4[1] = w1;
    apply_stimulus(4'b0010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick4();
      check("bp_hold_data", {24'b0, od4}, {24'b0, w0});
      check("bp_hold_cnt",  {16'b0, cnt4}, 32'd1);
    end
    apply_stimulus(4'b0010, 1'b1);
    tick4();
    check("bp_release_data", {24'b0, od4}, {24'b0, w1});
    check("bp_release_cnt",  {16'b0, cnt4}, 32'd2);
    apply_stimulus(4'b0000, 1'b1);
    tick4();

    $display("[TB] protocol error");
    reset4();
    d4[3] = 8'($urandom);
    apply_stimulus(4'b1000, 1'b1);
    tick4();
    apply_stimulus(4'b1000, 1'b0);
    tick4();
    apply_stimulus(4'b0000, 1'b0);
    tick4();
    check("perr_set", {31'b0, err4}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(4'($urandom), 1'($urandom));
      tick4();
      check("perr_sticky", {31'b0, err4}, 32'd1);
    end
    reset4();
    check("perr_clear", {31'b0, err4}, 32'd0);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(p_v[i] && !p_r[i])) begin
          v4[i] = 1'($urandom_range(0, 1));
          d4[i] = 8'($urandom);
        end
      end
      ordy4 = ($urandom_range(0, 3) != 0);
      if (k == 150) rst4 = 1'b1;
      tick4();
      rst4 = 1'b0;
    end
    apply_stimulus(4'b0000, 1'b1);
    tick4();

    $display("[TB] N=3 wrap and counter saturation");
    v3 = 3'b111;
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("n3_idx",  {30'b0, oi3}, 32'(k % 3));
      check("n3_data", {24'b0, od3}, 32'h20 + 32'(k % 3));
      check("n3_cnt",  {16'b0, cnt3}, (k + 1 < 65535) ? 32'(k + 1) : 32'd65535);
    end
    check("n3_valid", {31'b0, ov3}, 32'd1);
    check("n3_perr",  {31'b0, err3}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
